spi_axi_lite_burst_master: RTL and testbench

- Parametrised successor to the SPI-to-AXI-lite bridge master side.
- Accepts decoded SPI commands (already in the clk_i domain) and issues AXI-lite transactions of any data width.
- Adds multi-word bursts: one command expands into N sequential single-beat AXI-lite transfers with auto-incremented address.
- Adds sticky error reporting and a per-command beat count.

---
 rtl/spi_axi_lite_burst_master.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_spi_axi_lite_burst_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_axi_lite_burst_master.sv
// -----------------------------------------------------------------------------
// spi_axi_lite_burst_master
//
// Master side of the SPI-to-AXI-lite bridge. It takes decoded SPI commands
// that are already in the clk_i domain and runs them as AXI-lite transfers.
// One command becomes len+1 single-beat transfers. The address increases by
// DataWidth/8 after each beat and wraps modulo 2**AddrWidth.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake (ready only in IDLE)
//   cmd_write_i, cmd_addr_i        burst direction, aligned start byte address
//   cmd_len_i                      beats minus one
//   wdata_valid_i/wdata_ready_o    write data beat handshake, wdata_i
//   rdata_valid_o/rdata_ready_i    read data beat handshake, rdata_o
//   done_o                         one-cycle pulse at the end of a command
//   err_o, err_clr_i               sticky SLVERR/DECERR (or timeout) flag, clear
//   beats_o                        beats completed in the current/last command
//   timeout_o                      sticky watchdog flag
//   axi_lite_req_o/axi_lite_rsp_i  AXI-lite master request/response
//
// Optional feature
//   SPI_AXI_LITE_TIMEOUT_EN: when defined, a watchdog counts cycles in which an
//   AXI valid/ready is waiting for its handshake. It sets timeout_o and err_o
//   after TimeoutCycles. When undefined, timeout_o is tied low.
// -----------------------------------------------------------------------------

package spi_axi_lite_burst_master_pkg;
  // Default 32-bit AXI-lite channel structs. Parents with other widths
  // pass their own types through the type parameters.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_32_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_32_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_32_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_32_t;

  typedef struct packed {
    ax_32_t aw;
    logic   aw_valid;
    w_32_t  w;
    logic   w_valid;
    logic   b_ready;
    ax_32_t ar;
    logic   ar_valid;
    logic   r_ready;
  } req_32_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    b_32_t  b;
    logic   b_valid;
    logic   ar_ready;
    r_32_t  r;
    logic   r_valid;
  } rsp_32_t;
endpackage

module spi_axi_lite_burst_master #(
  parameter type         axi_lite_req_t = spi_axi_lite_burst_master_pkg::req_32_t,
  parameter type         axi_lite_rsp_t = spi_axi_lite_burst_master_pkg::rsp_32_t,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LenWidth       = 8,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic                 err_clr_i,
  output logic [LenWidth:0]    beats_o,
  output logic                 timeout_o,
  output axi_lite_req_t        axi_lite_req_o,
  input  axi_lite_rsp_t        axi_lite_rsp_i
);

  localparam int unsigned ByteStep = DataWidth / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RD_OUT,
    ST_DONE
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_len;
  logic [DataWidth-1:0] r_wdata;
  logic [DataWidth-1:0] r_rdata;
  logic [LenWidth:0]    r_beats;
  logic                 r_aw_valid;
  logic                 r_w_valid;
  logic                 r_err;

  logic w_last;
  logic w_b_hs;
  logic w_r_hs;
  logic w_out_hs;
  logic w_beat_done;
  logic w_err_set;
  logic w_to_set;

  // The beat counter has not been bumped yet for the beat in flight, so the
  // last beat is the one that starts with beats == len.
  assign w_last      = (r_beats == {1'b0, r_len});
  assign w_b_hs      = (r_state == ST_WR_RESP) && axi_lite_rsp_i.b_valid;
  assign w_r_hs      = (r_state == ST_RD_DATA) && axi_lite_rsp_i.r_valid;
  assign w_out_hs    = (r_state == ST_RD_OUT) && rdata_ready_i;
  assign w_beat_done = w_b_hs || w_out_hs;

  // A non-OKAY response never aborts the burst; it only raises the flag.
  assign w_err_set = (w_b_hs && (axi_lite_rsp_i.b.resp != 2'b00)) ||
                     (w_r_hs && (axi_lite_rsp_i.r.resp != 2'b00)) ||
                     w_to_set;

  always_comb begin
    w_state_nxt    = r_state;
    cmd_ready_o    = 1'b0;
    wdata_ready_o  = 1'b0;
    rdata_valid_o  = 1'b0;
    done_o         = 1'b0;
    axi_lite_req_o = '0;

    // Address and data come straight from registers. They only change
    // outside the state that holds the matching valid high.
    axi_lite_req_o.aw.addr  = r_addr;
    axi_lite_req_o.aw.prot  = 3'b000;
    axi_lite_req_o.aw_valid = r_aw_valid;
    axi_lite_req_o.w.data   = r_wdata;
    axi_lite_req_o.w.strb   = '1;
    axi_lite_req_o.w_valid  = r_w_valid;
    axi_lite_req_o.ar.addr  = r_addr;
    axi_lite_req_o.ar.prot  = 3'b000;

    unique case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_state_nxt = cmd_write_i ? ST_WR_DATA : ST_RD_ADDR;
        end
      end
      ST_WR_DATA: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          w_state_nxt = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        // AW and W finish on their own; leave once neither is outstanding.
        if ((!r_aw_valid || axi_lite_rsp_i.aw_ready) &&
            (!r_w_valid  || axi_lite_rsp_i.w_ready)) begin
          w_state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        axi_lite_req_o.b_ready = 1'b1;
        if (axi_lite_rsp_i.b_valid) begin
          w_state_nxt = w_last ? ST_DONE : ST_WR_DATA;
        end
      end
      ST_RD_ADDR: begin
        axi_lite_req_o.ar_valid = 1'b1;
        if (axi_lite_rsp_i.ar_ready) begin
          w_state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        axi_lite_req_o.r_ready = 1'b1;
        if (axi_lite_rsp_i.r_valid) begin
          w_state_nxt = ST_RD_OUT;
        end
      end
      ST_RD_OUT: begin
        rdata_valid_o = 1'b1;
        if (rdata_ready_i) begin
          w_state_nxt = w_last ? ST_DONE : ST_RD_ADDR;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_beats    <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_IDLE && cmd_valid_i) begin
        r_beats <= '0;
      end else if (w_beat_done) begin
        r_beats <= r_beats + {{LenWidth{1'b0}}, 1'b1};
      end

      // AW and W are raised together and each drops on its own handshake.
      if (r_state == ST_WR_DATA && wdata_valid_i) begin
        r_aw_valid <= 1'b1;
        r_w_valid  <= 1'b1;
      end else begin
        if (axi_lite_rsp_i.aw_ready) r_aw_valid <= 1'b0;
        if (axi_lite_rsp_i.w_ready)  r_w_valid  <= 1'b0;
      end

      if (w_r_hs) begin
        r_rdata <= axi_lite_rsp_i.r.data;
      end

      // If a new error and a clear land in the same cycle, the error wins.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  // Burst address, length and write holding register. These are only
  // meaningful after a command is accepted, so they have no reset.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && cmd_valid_i) begin
      r_addr <= cmd_addr_i;
      r_len  <= cmd_len_i;
    end else if (w_beat_done) begin
      r_addr <= r_addr + AddrWidth'(ByteStep);
    end
    if (r_state == ST_WR_DATA && wdata_valid_i) begin
      r_wdata <= wdata_i;
    end
  end

`ifdef SPI_AXI_LITE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_pending;
  logic            w_any_hs;

  // "Pending" means a valid or ready is raised and its handshake has not
  // happened this cycle.
  assign w_pending = (r_aw_valid && !axi_lite_rsp_i.aw_ready) ||
                     (r_w_valid  && !axi_lite_rsp_i.w_ready)  ||
                     ((r_state == ST_WR_RESP) && !axi_lite_rsp_i.b_valid) ||
                     ((r_state == ST_RD_ADDR) && !axi_lite_rsp_i.ar_ready) ||
                     ((r_state == ST_RD_DATA) && !axi_lite_rsp_i.r_valid);
  assign w_any_hs  = (r_aw_valid && axi_lite_rsp_i.aw_ready) ||
                     (r_w_valid  && axi_lite_rsp_i.w_ready)  ||
                     w_b_hs || w_r_hs ||
                     ((r_state == ST_RD_ADDR) && axi_lite_rsp_i.ar_ready);
  assign w_to_set  = w_pending && !w_any_hs &&
                     (r_to_cnt == CntW'(TimeoutCycles - 1));

  // The counter saturates, so a long stall flags only once. The FSM keeps
  // waiting, which stays protocol-legal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_any_hs || !w_pending) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != CntW'(TimeoutCycles)) begin
        r_to_cnt <= r_to_cnt + {{(CntW-1){1'b0}}, 1'b1};
      end

      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (err_clr_i) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_to_set  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign rdata_o = r_rdata;
  assign err_o   = r_err;
  assign beats_o = r_beats;

endmodule

// File: tb/tb_spi_axi_lite_burst_master.sv
// -----------------------------------------------------------------------------
// Testbench for spi_axi_lite_burst_master.
//
// A randomized AXI-lite slave has independent per-channel ready/valid delays.
// A write-data feeder and a read-data consumer sit beside it. The reference
// model builds each command from plain arithmetic:
//   - the beat addresses are start + 4*i (32-bit wrap),
//   - the data and responses are chosen up front,
//   - err is the OR of the non-OKAY responses since the last clear,
//   - the beat count is len+1.
// It then compares what the slave saw and what the DUT reported.
// -----------------------------------------------------------------------------

module tb_spi_axi_lite_burst_master;
  import spi_axi_lite_burst_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [31:0] wdata_i;
  logic        rdata_valid_o, rdata_ready_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, err_clr_i, timeout_o;
  logic [8:0]  beats_o;
  req_32_t     req;
  rsp_32_t     rsp;

  always #5 clk = ~clk;

  spi_axi_lite_burst_master #(
    .axi_lite_req_t(req_32_t),
    .axi_lite_rsp_t(rsp_32_t),
    .AddrWidth     (32),
    .DataWidth     (32),
    .LenWidth      (8),
    .TimeoutCycles (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .rdata_o       (rdata_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i),
    .beats_o       (beats_o),
    .timeout_o     (timeout_o),
    .axi_lite_req_o(req),
    .axi_lite_rsp_i(rsp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave / environment knobs (negative delay = random 0..3 cycles)
  int aw_dly = -1, w_dly = -1, b_dly = -1, ar_dly = -1, r_dly = -1, rr_dly = -1;
  bit clr_on_err = 1'b0;
  bit clr_pulse  = 1'b0;

  // Stimulus handed to the environment, and what the slave observed
  logic [31:0] wfeed_q[$], rdat_q[$], aw_log[$], w_log[$], ar_log[$], rd_got[$];
  logic [3:0]  strb_log[$];
  logic [1:0]  bresp_q[$], rresp_q[$];
  int n_aw, n_w, n_b, n_ar, n_r, done_cnt, viol;

  task automatic gate(input logic v, input int dly, inout int cnt, inout int tgt, output logic rdy);
    if (!v) begin
      rdy = 1'b0;
      cnt = 0;
    end else begin
      if (cnt == 0) tgt = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      rdy = (cnt >= tgt);
      if (rdy) cnt = 0;
      else     cnt++;
    end
  endtask

  // Environment: everything is decided on the falling edge and takes effect
  // at the next rising edge. Handshakes are therefore logged here.
  initial begin
    int awc, awt, wc, wt, bc, bt, arc, art, rc, rt, oc, ot;
    bit b_hold, r_hold, wd_taken, go, b_err_hs;
    logic t;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_ov, p_or;
    logic [31:0] p_awa, p_wd, p_ara, p_od;
    rsp = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b0; err_clr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp = '0;
        wdata_valid_i = 1'b0; rdata_ready_i = 1'b0; err_clr_i = 1'b0;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0; oc = 0;
        b_hold = 0; r_hold = 0; wd_taken = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_ov = 0;
        wfeed_q.delete(); rdat_q.delete(); bresp_q.delete(); rresp_q.delete();
      end else begin
        // Stability: a valid not handshaked last cycle must stay with same payload
        if (p_awv && !p_awr && !(req.aw_valid && req.aw.addr == p_awa)) viol++;
        if (p_wv  && !p_wr  && !(req.w_valid  && req.w.data  == p_wd))  viol++;
        if (p_arv && !p_arr && !(req.ar_valid && req.ar.addr == p_ara)) viol++;
        if (p_ov  && !p_or  && !(rdata_valid_o && rdata_o == p_od))     viol++;

        // B is only offered for beats whose AW and W both already completed
        b_err_hs = 1'b0;
        if (!b_hold) begin
          gate((n_aw > n_b) && (n_w > n_b), b_dly, bc, bt, t);
          if (t) begin
            b_hold = 1'b1;
            rsp.b.resp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          end
        end
        rsp.b_valid = b_hold;
        if (b_hold && req.b_ready) begin
          n_b++;
          b_hold = 1'b0;
          b_err_hs = (rsp.b.resp != 2'b00);
        end

        if (!r_hold) begin
          gate(n_ar > n_r, r_dly, rc, rt, t);
          if (t) begin
            r_hold = 1'b1;
            rsp.r.data = (rdat_q.size() > 0) ? rdat_q.pop_front() : $urandom;
            rsp.r.resp = (rresp_q.size() > 0) ? rresp_q.pop_front() : 2'b00;
          end
        end
        rsp.r_valid = r_hold;
        if (r_hold && req.r_ready) begin
          n_r++;
          r_hold = 1'b0;
        end

        gate(req.aw_valid, aw_dly, awc, awt, t); rsp.aw_ready = t;
        if (req.aw_valid && t) begin aw_log.push_back(req.aw.addr); n_aw++; end
        gate(req.w_valid, w_dly, wc, wt, t); rsp.w_ready = t;
        if (req.w_valid && t) begin
          w_log.push_back(req.w.data); strb_log.push_back(req.w.strb); n_w++;
        end
        gate(req.ar_valid, ar_dly, arc, art, t); rsp.ar_ready = t;
        if (req.ar_valid && t) begin ar_log.push_back(req.ar.addr); n_ar++; end

        if (wd_taken) begin wdata_valid_i = 1'b0; wd_taken = 1'b0; end
        if (!wdata_valid_i && wfeed_q.size() > 0) begin
          wdata_i = wfeed_q.pop_front();
          wdata_valid_i = 1'b1;
        end
        if (wdata_valid_i && wdata_ready_o) wd_taken = 1'b1;

        gate(rdata_valid_o, rr_dly, oc, ot, t); rdata_ready_i = t;
        if (rdata_valid_o && t) rd_got.push_back(rdata_o);

        if (done_o) done_cnt++;
        err_clr_i = clr_pulse || (clr_on_err && b_err_hs);
        clr_pulse = 1'b0;

        p_awv = req.aw_valid; p_awr = rsp.aw_ready; p_awa = req.aw.addr;
        p_wv  = req.w_valid;  p_wr  = rsp.w_ready;  p_wd  = req.w.data;
        p_arv = req.ar_valid; p_arr = rsp.ar_ready; p_ara = req.ar.addr;
        p_ov  = rdata_valid_o; p_or = rdata_ready_i; p_od = rdata_o;
      end
    end
  end

  // Reference model state
  logic [31:0] stim_d[$];
  logic [1:0]  stim_r[$];
  bit          model_err = 1'b0;
  bit          model_to  = 1'b0;

  task automatic run_and_check(input string nm, input bit wr, input logic [31:0] addr, input int len);
    int d0, b0, n, lim;
    logic [31:0] ea;
    for (int i = 0; i <= len; i++) if (stim_r[i] != 2'b00) model_err = 1'b1;
    aw_log.delete(); w_log.delete(); strb_log.delete(); ar_log.delete(); rd_got.delete();
    if (wr) begin
      foreach (stim_d[i]) wfeed_q.push_back(stim_d[i]);
      foreach (stim_r[i]) bresp_q.push_back(stim_r[i]);
    end else begin
      foreach (stim_d[i]) rdat_q.push_back(stim_d[i]);
      foreach (stim_r[i]) rresp_q.push_back(stim_r[i]);
    end
    d0 = done_cnt;
    b0 = n_b;
    @(posedge clk); #1;
    n = 0;
    while (!cmd_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = 8'(len);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    lim = 60 * (len + 1) + 200;
    n = 0;
    while (done_cnt == d0 && n < lim) begin @(posedge clk); n++; end
    #1;
    if (done_cnt == d0) begin
      chk({nm, "_done_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_beats"}, beats_o, 64'(len + 1));
    chk({nm, "_err"}, err_o, model_err);
    chk({nm, "_timeout"}, timeout_o, model_to);
    if (wr) begin
      chk({nm, "_aw_cnt"}, aw_log.size(), len + 1);
      chk({nm, "_w_cnt"}, w_log.size(), len + 1);
      chk({nm, "_b_cnt"}, n_b - b0, len + 1);
      for (int i = 0; i <= len && i < aw_log.size() && i < w_log.size(); i++) begin
        ea = addr + 32'(4 * i);
        chk($sformatf("%s_aw%0d", nm, i), aw_log[i], ea);
        chk($sformatf("%s_w%0d", nm, i), w_log[i], stim_d[i]);
        chk($sformatf("%s_strb%0d", nm, i), strb_log[i], 4'hF);
      end
    end else begin
      chk({nm, "_ar_cnt"}, ar_log.size(), len + 1);
      chk({nm, "_rd_cnt"}, rd_got.size(), len + 1);
      for (int i = 0; i <= len && i < ar_log.size() && i < rd_got.size(); i++) begin
        ea = addr + 32'(4 * i);
        chk($sformatf("%s_ar%0d", nm, i), ar_log[i], ea);
        chk($sformatf("%s_rd%0d", nm, i), rd_got[i], stim_d[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic fill(input int len, input bit rand_err);
    stim_d.delete(); stim_r.delete();
    for (int i = 0; i <= len; i++) begin
      stim_d.push_back($urandom);
      if (rand_err && $urandom_range(0, 7) == 0) stim_r.push_back($urandom_range(0, 1) ? 2'b10 : 2'b11);
      else stim_r.push_back(2'b00);
    end
  endtask

  task automatic clear_err();
    clr_pulse = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_err = 1'b0;
    model_to  = 1'b0;
    chk("clr_err", err_o, 0);
    chk("clr_timeout", timeout_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int len;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    done_cnt = 0; viol = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready,
                       wdata_ready_o, rdata_valid_o, done_o}, 8'h00);
    chk("rst_err", {err_o, timeout_o}, 2'b00);
    chk("rst_beats", beats_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_prot", {req.aw.prot, req.ar.prot}, 6'o00);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    rst_n = 1'b1;

    // Single write
    stim_d = '{32'hDEADBEEF}; stim_r = '{2'b00};
    run_and_check("single_wr", 1'b1, 32'h1000, 0);

    // Read burst with fixed data
    stim_d = '{32'h11, 32'h22, 32'h33, 32'h44}; stim_r = '{2'b00, 2'b00, 2'b00, 2'b00};
    run_and_check("rd_burst", 1'b0, 32'h2000, 3);

    // Independent AW/W timing, both orders
    aw_dly = 0; w_dly = 3;
    fill(1, 1'b0); run_and_check("aw_first", 1'b1, 32'h3000, 1);
    aw_dly = 3; w_dly = 0;
    fill(1, 1'b0); run_and_check("w_first", 1'b1, 32'h3100, 1);
    aw_dly = -1; w_dly = -1;

    // Error continuation: SLVERR on beat 2 of 4, sticky until cleared
    fill(3, 1'b0); stim_r[1] = 2'b10;
    run_and_check("err_cont", 1'b1, 32'h4000, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", err_o, 1);
    clear_err();

    // Clear in the same cycle as a new error: the set wins
    clr_on_err = 1'b1;
    fill(0, 1'b0); stim_r[0] = 2'b11;
    run_and_check("set_wins", 1'b1, 32'h4100, 0);
    clr_on_err = 1'b0;
    clear_err();

    // Address wrap, write and read
    fill(1, 1'b0); run_and_check("wrap_wr", 1'b1, 32'hFFFF_FFFC, 1);
    fill(1, 1'b0); run_and_check("wrap_rd", 1'b0, 32'hFFFF_FFFC, 1);

    // Maximum length burst (256 beats)
    fill(255, 1'b0); run_and_check("max_rd", 1'b0, 32'h8000, 255);

    // Randomized commands
    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(0, 7);
      fill(len, 1'b1);
      run_and_check($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                    {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, len);
      if (k % 6 == 5) clear_err();
    end
    clear_err();

    // Stalled AR: watchdog fires when the feature is built in
    ar_dly = 30;
    fill(0, 1'b0);
`ifdef SPI_AXI_LITE_TIMEOUT_EN
    model_err = 1'b1;
    model_to  = 1'b1;
`endif
    fork
      run_and_check("ar_stall", 1'b0, 32'h5000, 0);
      begin
        repeat (24) @(posedge clk);
        #1;
        chk("stall_ar_valid", req.ar_valid, 1);
`ifdef SPI_AXI_LITE_TIMEOUT_EN
        chk("stall_timeout", timeout_o, 1);
`else
        chk("stall_timeout", timeout_o, 0);
`endif
      end
    join
    ar_dly = -1;
    clear_err();

    chk("protocol_violations", viol, 0);

    // Asynchronous reset in the middle of a burst
    ar_dly = 1000;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h6000; cmd_len_i = 8'd3;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_ar_valid", req.ar_valid, 1);
    chk("mid_cmd_ready", cmd_ready_o, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ar_valid", req.ar_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready_o, 1);
    chk("mid_rst_beats", beats_o, 0);
    repeat (2) @(posedge clk);
    #1;
    ar_dly = -1;
    rst_n = 1'b1;
    model_err = 1'b0;
    model_to  = 1'b0;
    fill(2, 1'b0); run_and_check("post_rst_rd", 1'b0, 32'h7000, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
